lcd_pattern_gen: RTL and testbench
==================================

LCD_PATTERN_GEN -- requirements
Module: lcd_pattern_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- H_RES, 128, pixels per line.
- V_RES, 160, lines per frame.
- CHECK_SHIFT, 3, log2 of checker square size.
- BAR_SHIFT, 4, log2 of colour-bar width in pixels.
- SOLID_COLOR, 16'hF800, mode-0 colour.
- FRAME_HOLD, 60, frames per mode in auto-cycle, range 1..255.
- BUSY_TIMEOUT, 255, WAIT_BUSY cycles before retry, range 1..255.
REQ-002 The design SHALL use one clock and an asynchronous, active-high reset. Ports (name, direction, width, meaning):
- SYSTEM_CLK, in, 1, clock.
- SYSTEM_RESET, in, 1, asynchronous active-high reset.
- ENABLE, in, 1, run.
- LCD_READY, in, 1, driver initialised.
- IS_BUSY, in, 1, driver transferring a pixel.
- MODE, in, 3, pattern select.
- AUTO_CYCLE, in, 1, ignore MODE and rotate patterns.
- WRITE_EN, out, 1, pixel strobe.
- COLOR_PIXEL, out, 16, RGB565 pixel.
- X, out, clog2(H_RES), current column.
- Y, out, clog2(V_RES), current row.
- ACTIVE_MODE, out, 3, mode of the current frame.
- FRAME_DONE, out, 1, one-cycle pulse per completed frame.
- FRAME_CNT, out, 8, completed frames, wraps.
- LED_STAT, out, 1, toggles per frame.

Function
REQ-003 FSM states SHALL be IDLE, WAIT_BUSY and WAIT_DONE.
REQ-004 In IDLE with ENABLE=1, LCD_READY=1 and IS_BUSY=0, the next edge SHALL set WRITE_EN=1 for exactly one cycle, register COLOR_PIXEL for (X,Y) on that same edge, and move to WAIT_BUSY.
REQ-005 In WAIT_BUSY, IS_BUSY=1 SHALL move the FSM to WAIT_DONE; if IS_BUSY is not seen for BUSY_TIMEOUT cycles, the FSM SHALL return to IDLE without advancing, so the same pixel is re-issued.
REQ-006 In WAIT_DONE, IS_BUSY=0 SHALL advance the pixel and return to IDLE; a pixel SHALL therefore never be strobed twice once accepted.
REQ-007 COLOR_PIXEL, X and Y SHALL stay stable from the WRITE_EN cycle until the pixel advances.
REQ-008 Advance SHALL increment X. At X=H_RES-1, X SHALL become 0 and Y SHALL increment. At X=H_RES-1 and Y=V_RES-1, both SHALL become 0, FRAME_CNT SHALL increment (wrapping 255->0), FRAME_DONE SHALL pulse for one cycle and LED_STAT SHALL toggle.
REQ-009 ACTIVE_MODE SHALL be loaded only on the WRITE_EN edge of pixel (0,0): from MODE if AUTO_CYCLE=0, else from auto_mode. A frame SHALL never mix patterns.
REQ-010 An internal hold counter SHALL count completed frames; on reaching FRAME_HOLD it SHALL clear and auto_mode SHALL step 0,1,2,3,4,0.
REQ-011 Pattern colours (16 bits, RGB565):
- 0: SOLID_COLOR.
- 1: (Y*H_RES+X) mod 2^16.
- 2: bar = (X>>BAR_SHIFT) mod 8, mapped to FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
- 3: FFFF if bit0 of ((X>>CHECK_SHIFT) xor (Y>>CHECK_SHIFT)) is 1, else 0000.
- 4: {R=(X>>2)[4:0], G=(Y>>2)[5:0], B=FRAME_CNT[4:0]}.
- 5-7: treated as 0.
REQ-012 Mode 1 SHALL use a running index counter (no multiplier), cleared at frame wrap.
REQ-013 ENABLE or LCD_READY dropping mid-transaction SHALL not abort it; the FSM SHALL finish WAIT_DONE, then hold in IDLE at the next pixel and resume there.
REQ-014 IS_BUSY=1 while in IDLE SHALL block issue.

Reset
REQ-015 SYSTEM_RESET=1 SHALL immediately force the following, at any time including mid-transaction: state=IDLE, WRITE_EN=0, COLOR_PIXEL=0, X=0, Y=0, ACTIVE_MODE=0, auto_mode=0, hold counter=0, FRAME_CNT=0, FRAME_DONE=0, LED_STAT=0, timeout counter=0.
REQ-016 After reset, the first strobe SHALL be pixel (0,0) and SHALL reload ACTIVE_MODE.

Verification (H_RES=4, V_RES=2, BAR_SHIFT=1, FRAME_HOLD=2, BUSY_TIMEOUT=4)
REQ-017 Basic handshake: MODE=0, IS_BUSY model goes high 1 cycle after WRITE_EN for 3 cycles -> 8 single-cycle strobes of F800, X/Y sequence (0,0)..(3,1), one FRAME_DONE, FRAME_CNT=1, LED_STAT=1.
REQ-018 Colour bars: MODE=2 -> line colours FFFF, FFFF, FFE0, FFE0; MODE=3 with CHECK_SHIFT=0 -> row 0 is 0000, FFFF, 0000, FFFF.
REQ-019 Timeout: IS_BUSY held 0 -> WRITE_EN re-pulses every 6 cycles with X=0 and Y=0 unchanged.
REQ-020 Auto cycle: AUTO_CYCLE=1 for 10 frames -> ACTIVE_MODE per frame is 0,0,1,1,2,2,3,3,4,4; a MODE change mid-frame leaves ACTIVE_MODE unchanged until (0,0).
REQ-021 Stall: LCD_READY dropped during WAIT_DONE of pixel (2,0) -> pixel completes, no strobe while low, next strobe is (3,0).
REQ-022 Reset mid-transaction in WAIT_BUSY at pixel (1,1) -> all outputs are 0 in the same cycle, and the next strobe is (0,0).

Source files
------------

// File: rtl/lcd_pattern_gen_if.sv
// Pixel-stream bundle between the pattern generator and an LCD pixel driver.
interface lcd_pattern_gen_if #(
   parameter int unsigned XW = 7,
   parameter int unsigned YW = 8
);
   // Control and driver status into the generator
   logic          ENABLE;
   logic          LCD_READY;
   logic          IS_BUSY;
   logic [2:0]    MODE;
   logic          AUTO_CYCLE;
   // Pixel stream and frame status out of the generator
   logic          WRITE_EN;
   logic [15:0]   COLOR_PIXEL;
   logic [XW-1:0] X;
   logic [YW-1:0] Y;
   logic [2:0]    ACTIVE_MODE;
   logic          FRAME_DONE;
   logic [7:0]    FRAME_CNT;
   logic          LED_STAT;

   // Generator side
   modport master (
      input  ENABLE, LCD_READY, IS_BUSY, MODE, AUTO_CYCLE,
      output WRITE_EN, COLOR_PIXEL, X, Y, ACTIVE_MODE, FRAME_DONE, FRAME_CNT, LED_STAT
   );

   // Driver / controller side
   modport slave (
      output ENABLE, LCD_READY, IS_BUSY, MODE, AUTO_CYCLE,
      input  WRITE_EN, COLOR_PIXEL, X, Y, ACTIVE_MODE, FRAME_DONE, FRAME_CNT, LED_STAT
   );
endinterface

// File: rtl/lcd_pattern_gen.sv
// LCD test-pattern generator: walks the frame pixel by pixel, strobing one
// RGB565 colour per pixel through a busy handshake with the LCD driver.
module lcd_pattern_gen #(
   parameter int unsigned H_RES        = 128,
   parameter int unsigned V_RES        = 160,
   parameter int unsigned CHECK_SHIFT  = 3,
   parameter int unsigned BAR_SHIFT    = 4,
   parameter logic [15:0] SOLID_COLOR  = 16'hF800,
   parameter int unsigned FRAME_HOLD   = 60,
   parameter int unsigned BUSY_TIMEOUT = 255
) (
   input logic               SYSTEM_CLK,
   input logic               SYSTEM_RESET,
   lcd_pattern_gen_if.master bus
);

   localparam int unsigned XW = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int unsigned YW = (V_RES > 1) ? $clog2(V_RES) : 1;

   localparam logic [XW-1:0] X_LAST    = XW'(H_RES - 1);
   localparam logic [YW-1:0] Y_LAST    = YW'(V_RES - 1);
   localparam logic [7:0]    HOLD_LAST = 8'(FRAME_HOLD - 1);
   localparam logic [7:0]    TMO_LAST  = 8'(BUSY_TIMEOUT);
   localparam logic [2:0]    AUTO_LAST = 3'd4;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   state_t        state;
   logic          write_en_q;
   logic [15:0]   color_q;
   logic [2:0]    active_mode_q;
   logic [7:0]    tmo_cnt_q;
   logic [XW-1:0] x_q;
   logic [YW-1:0] y_q;
   logic [15:0]   index_q;
   logic [7:0]    frame_cnt_q;
   logic          frame_done_q;
   logic          led_q;
   logic [7:0]    hold_cnt_q;
   logic [2:0]    auto_mode_q;

   logic          at_origin_c;
   logic          issue_c;
   logic          advance_c;
   logic          line_end_c;
   logic          frame_end_c;
   logic [2:0]    mode_sel_c;
   logic [15:0]   pixel_c;
   logic [15:0]   x_ext_c;
   logic [15:0]   y_ext_c;
   logic [2:0]    bar_sel_c;
   logic          check_c;
   logic [4:0]    red_c;
   logic [5:0]    green_c;

   assign at_origin_c = (x_q == '0) && (y_q == '0);
   assign issue_c     = (state == IDLE) && bus.ENABLE && bus.LCD_READY && !bus.IS_BUSY;
   assign advance_c   = (state == WAIT_DONE) && !bus.IS_BUSY;
   assign line_end_c  = (x_q == X_LAST);
   assign frame_end_c = advance_c && line_end_c && (y_q == Y_LAST);

   // Mode is only re-sampled at the first pixel so a frame never mixes patterns
   always_comb begin
      mode_sel_c = active_mode_q;
      if (at_origin_c) begin
         mode_sel_c = bus.AUTO_CYCLE ? auto_mode_q : bus.MODE;
      end
   end

   // Colour of the current pixel under the selected pattern
   always_comb begin
      x_ext_c   = 16'(x_q);
      y_ext_c   = 16'(y_q);
      bar_sel_c = 3'(x_ext_c >> BAR_SHIFT);
      check_c   = 1'(x_ext_c >> CHECK_SHIFT) ^ 1'(y_ext_c >> CHECK_SHIFT);
      red_c     = 5'(x_ext_c >> 2);
      green_c   = 6'(y_ext_c >> 2);
      pixel_c   = SOLID_COLOR;
      case (mode_sel_c)
         3'd1: pixel_c = index_q;
         3'd2: begin
            case (bar_sel_c)
               3'd0:    pixel_c = 16'hFFFF;
               3'd1:    pixel_c = 16'hFFE0;
               3'd2:    pixel_c = 16'h07FF;
               3'd3:    pixel_c = 16'h07E0;
               3'd4:    pixel_c = 16'hF81F;
               3'd5:    pixel_c = 16'hF800;
               3'd6:    pixel_c = 16'h001F;
               default: pixel_c = 16'h0000;
            endcase
         end
         3'd3:    pixel_c = check_c ? 16'hFFFF : 16'h0000;
         3'd4:    pixel_c = {red_c, green_c, frame_cnt_q[4:0]};
         default: pixel_c = SOLID_COLOR;
      endcase
   end

   // Handshake FSM: strobe once, wait for the driver to take and finish the pixel
   always_ff @(posedge SYSTEM_CLK or posedge SYSTEM_RESET) begin
      if (SYSTEM_RESET) begin
         state         <= IDLE;
         write_en_q    <= 1'b0;
         color_q       <= '0;
         active_mode_q <= '0;
         tmo_cnt_q     <= '0;
      end else begin
         write_en_q <= 1'b0;
         case (state)
            IDLE: begin
               if (issue_c) begin
                  write_en_q <= 1'b1;
                  color_q    <= pixel_c;
                  tmo_cnt_q  <= '0;
                  state      <= WAIT_BUSY;
                  if (at_origin_c) begin
                     active_mode_q <= mode_sel_c;
                  end
               end
            end
            WAIT_BUSY: begin
               if (bus.IS_BUSY) begin
                  tmo_cnt_q <= '0;
                  state     <= WAIT_DONE;
               end else if (tmo_cnt_q == TMO_LAST) begin
                  // Driver never took the pixel: go back and strobe it again
                  tmo_cnt_q <= '0;
                  state     <= IDLE;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 8'd1;
               end
            end
            WAIT_DONE: begin
               if (!bus.IS_BUSY) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Raster position and running linear index, stepped once per accepted pixel
   always_ff @(posedge SYSTEM_CLK or posedge SYSTEM_RESET) begin
      if (SYSTEM_RESET) begin
         x_q     <= '0;
         y_q     <= '0;
         index_q <= '0;
      end else if (advance_c) begin
         if (line_end_c) begin
            x_q <= '0;
            if (y_q == Y_LAST) begin
               y_q     <= '0;
               index_q <= '0;
            end else begin
               y_q     <= y_q + YW'(1);
               index_q <= index_q + 16'd1;
            end
         end else begin
            x_q     <= x_q + XW'(1);
            index_q <= index_q + 16'd1;
         end
      end
   end

   // Frame bookkeeping: counter, done pulse, LED toggle and auto-cycle stepping
   always_ff @(posedge SYSTEM_CLK or posedge SYSTEM_RESET) begin
      if (SYSTEM_RESET) begin
         frame_cnt_q  <= '0;
         frame_done_q <= 1'b0;
         led_q        <= 1'b0;
         hold_cnt_q   <= '0;
         auto_mode_q  <= '0;
      end else begin
         frame_done_q <= 1'b0;
         if (frame_end_c) begin
            frame_cnt_q  <= frame_cnt_q + 8'd1;
            frame_done_q <= 1'b1;
            led_q        <= ~led_q;
            if (hold_cnt_q == HOLD_LAST) begin
               hold_cnt_q  <= '0;
               auto_mode_q <= (auto_mode_q == AUTO_LAST) ? 3'd0 : auto_mode_q + 3'd1;
            end else begin
               hold_cnt_q <= hold_cnt_q + 8'd1;
            end
         end
      end
   end

   assign bus.WRITE_EN    = write_en_q;
   assign bus.COLOR_PIXEL = color_q;
   assign bus.X           = x_q;
   assign bus.Y           = y_q;
   assign bus.ACTIVE_MODE = active_mode_q;
   assign bus.FRAME_DONE  = frame_done_q;
   assign bus.FRAME_CNT   = frame_cnt_q;
   assign bus.LED_STAT    = led_q;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Scoreboard bench for lcd_pattern_gen on a 4x2 frame.
`timescale 1ns/1ps
module tb_lcd_pattern_gen;

   localparam int unsigned XW = 2;
   localparam int unsigned YW = 1;

   typedef struct {
      int          x;
      int          y;
      logic [15:0] color;
      int          mode;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic busy_off;
   logic prev_we = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   fd_count = 0;
   int   bcnt = 0;
   exp_t exp_q[$];
   int   strobe_cyc[$];

   lcd_pattern_gen_if #(.XW(XW), .YW(YW)) bus ();

   lcd_pattern_gen #(
      .H_RES(4), .V_RES(2), .CHECK_SHIFT(0), .BAR_SHIFT(1),
      .SOLID_COLOR(16'hF800), .FRAME_HOLD(2), .BUSY_TIMEOUT(4)
   ) dut (
      .SYSTEM_CLK(clk),
      .SYSTEM_RESET(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string name, int act, int expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, expv);
      end
   endfunction

   // Hand-computed colours for the 4x2 frame, BAR_SHIFT=1, CHECK_SHIFT=0
   function automatic logic [15:0] exp_color(int m, int x, int y, int fc);
      logic [15:0] bars [4];
      logic [15:0] chks [2][4];
      bars = '{16'hFFFF, 16'hFFFF, 16'hFFE0, 16'hFFE0};
      chks = '{'{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF},
               '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000}};
      case (m)
         1:       return 16'(y * 4 + x);
         2:       return bars[x];
         3:       return chks[y][x];
         4:       return 16'(fc % 32);
         default: return 16'hF800;
      endcase
   endfunction

   task automatic push_pixels(int mode, int fc, int count);
      for (int i = 0; i < count; i++) begin
         exp_q.push_back('{i % 4, i / 4, exp_color(mode, i % 4, i / 4, fc), mode});
      end
   endtask

   task automatic wait_size(int n, int budget, string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         #1;
         if (exp_q.size() <= n) ok = 1'b1;
      end
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_wait: queue size %0d required <= %0d", tag, exp_q.size(), n);
         exp_q.delete();
      end
   endtask

   task automatic check_zero(string tag);
      chk({tag, "_we"},    int'(bus.WRITE_EN), 0);
      chk({tag, "_color"}, int'(bus.COLOR_PIXEL), 0);
      chk({tag, "_x"},     int'(bus.X), 0);
      chk({tag, "_y"},     int'(bus.Y), 0);
      chk({tag, "_amode"}, int'(bus.ACTIVE_MODE), 0);
      chk({tag, "_fdone"}, int'(bus.FRAME_DONE), 0);
      chk({tag, "_fcnt"},  int'(bus.FRAME_CNT), 0);
      chk({tag, "_led"},   int'(bus.LED_STAT), 0);
   endtask

   // One full frame; MODE is changed right after pixel (0,0) is strobed
   task automatic run_frame(int mode, int mid_mode, int fc);
      bus.MODE = 3'(mode);
      push_pixels(mode, fc, 8);
      bus.ENABLE = 1'b1;
      wait_size(7, 60, "frame_first");
      bus.MODE = 3'(mid_mode);
      wait_size(0, 200, "frame_all");
      bus.ENABLE = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   // Driver model: busy from the cycle after a strobe, for three cycles
   always @(negedge clk) begin
      if (busy_off || rst) begin
         bus.IS_BUSY = 1'b0;
         bcnt = 0;
      end else if (bus.WRITE_EN) begin
         bus.IS_BUSY = 1'b1;
         bcnt = 2;
      end else if (bcnt > 0) begin
         bcnt--;
      end else begin
         bus.IS_BUSY = 1'b0;
      end
   end

   // Monitor: every strobe pops one expected pixel
   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.FRAME_DONE) fd_count++;
      if (!rst && bus.WRITE_EN) begin
         chk("strobe_single", int'(prev_we), 0);
         strobe_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_strobe: got x=%0d y=%0d required no strobe",
                     bus.X, bus.Y);
         end else begin
            e = exp_q.pop_front();
            chk("strobe_x",     int'(bus.X), e.x);
            chk("strobe_y",     int'(bus.Y), e.y);
            chk("strobe_color", int'(bus.COLOR_PIXEL), int'(e.color));
            chk("strobe_mode",  int'(bus.ACTIVE_MODE), e.mode);
         end
      end
      prev_we = bus.WRITE_EN;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int auto_modes [10];
      auto_modes = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4};
      rst            = 1'b1;
      busy_off       = 1'b0;
      bus.ENABLE     = 1'b0;
      bus.LCD_READY  = 1'b0;
      bus.MODE       = 3'd0;
      bus.AUTO_CYCLE = 1'b0;
      #1;
      check_zero("reset");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      bus.LCD_READY = 1'b1;

      // Basic handshake, solid colour
      run_frame(0, 5, 0);
      chk("basic_fcnt", int'(bus.FRAME_CNT), 1);
      chk("basic_led", int'(bus.LED_STAT), 1);
      chk("basic_fdone_pulses", fd_count, 1);

      // Colour bars, checker, index ramp, gradient
      run_frame(2, 3, 1);
      run_frame(3, 1, 2);
      run_frame(1, 4, 3);
      run_frame(4, 0, 4);
      chk("patterns_fcnt", int'(bus.FRAME_CNT), 5);
      chk("patterns_led", int'(bus.LED_STAT), 1);

      // LCD_READY dropped while pixel (2,0) is in WAIT_DONE
      bus.MODE = 3'd0;
      push_pixels(0, 5, 8);
      bus.ENABLE = 1'b1;
      wait_size(5, 60, "stall_reach");
      @(negedge clk);
      bus.LCD_READY = 1'b0;
      repeat (10) @(negedge clk);
      chk("stall_no_strobe", exp_q.size(), 5);
      chk("stall_x", int'(bus.X), 3);
      chk("stall_y", int'(bus.Y), 0);
      bus.LCD_READY = 1'b1;
      wait_size(0, 200, "stall_resume");
      bus.ENABLE = 1'b0;
      repeat (8) @(negedge clk);
      chk("stall_fcnt", int'(bus.FRAME_CNT), 6);

      // Driver never goes busy: same pixel re-strobed every 6 cycles
      busy_off = 1'b1;
      @(negedge clk);
      strobe_cyc.delete();
      push_pixels(0, 6, 1);
      push_pixels(0, 6, 1);
      push_pixels(0, 6, 1);
      bus.ENABLE = 1'b1;
      wait_size(0, 60, "timeout");
      bus.ENABLE = 1'b0;
      repeat (8) @(negedge clk);
      chk("timeout_strobes", strobe_cyc.size(), 3);
      if (strobe_cyc.size() >= 3) begin
         chk("timeout_gap1", strobe_cyc[1] - strobe_cyc[0], 6);
         chk("timeout_gap2", strobe_cyc[2] - strobe_cyc[1], 6);
      end
      chk("timeout_x", int'(bus.X), 0);
      chk("timeout_y", int'(bus.Y), 0);
      busy_off = 1'b0;
      @(negedge clk);

      // Reset while pixel (1,1) sits in WAIT_BUSY
      push_pixels(0, 6, 6);
      bus.ENABLE = 1'b1;
      wait_size(0, 100, "reset_reach");
      rst = 1'b1;
      #1;
      check_zero("midreset");

      // Auto-cycle from reset; MODE must be ignored
      bus.AUTO_CYCLE = 1'b1;
      bus.MODE = 3'd3;
      for (int f = 0; f < 10; f++) push_pixels(auto_modes[f], f, 8);
      repeat (2) @(negedge clk);
      fd_count = 0;
      rst = 1'b0;
      wait_size(72, 100, "auto_first");
      bus.MODE = 3'd2;
      wait_size(0, 1200, "auto_all");
      bus.ENABLE = 1'b0;
      repeat (8) @(negedge clk);
      chk("auto_fcnt", int'(bus.FRAME_CNT), 10);
      chk("auto_led", int'(bus.LED_STAT), 0);
      chk("auto_fdone_pulses", fd_count, 10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
